// File: rtl/cache_2way_wb.sv
// cache_2way_wb: 2-way set-associative write-back cache between a CPU Avalon slave and an Avalon burst master
module cache_2way_wb #(
    parameter int ADDR_WIDTH      = 32,
    parameter int LINE_WORDS_LOG2 = 4,
    parameter int INDEX_WIDTH     = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_WIDTH-1:0]      avalon_slave_address,
    input  logic                       avalon_slave_read,
    input  logic                       avalon_slave_write,
    input  logic [3:0]                 avalon_slave_byteenable,
    input  logic [31:0]                avalon_slave_writedata,
    output logic [31:0]                avalon_slave_readdata,
    output logic                       avalon_slave_waitrequest,
    output logic [ADDR_WIDTH-1:0]      avalon_master_address,
    output logic [LINE_WORDS_LOG2:0]   avalon_master_burstcount,
    output logic                       avalon_master_read,
    output logic                       avalon_master_write,
    output logic [31:0]                avalon_master_writedata,
    output logic [3:0]                 avalon_master_byteenable,
    input  logic [31:0]                avalon_master_readdata,
    input  logic                       avalon_master_readdatavalid,
    input  logic                       avalon_master_waitrequest
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - LINE_WORDS_LOG2 - 2;
    localparam int WORDS     = 1 << LINE_WORDS_LOG2;
    localparam int SETS      = 1 << INDEX_WIDTH;
    localparam int OFF       = LINE_WORDS_LOG2 + 2;
    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;
    state_t state, state_nx;
    logic [LINE_WORDS_LOG2-1:0] cnt, cnt_nx, a_word;
    logic [TAG_WIDTH-1:0] miss_tag, miss_tag_nx, a_tag;
    logic [INDEX_WIDTH-1:0] miss_idx, miss_idx_nx, a_idx;
    logic victim, victim_nx, miss_v;
    logic m_read_nx, m_write_nx;
    logic [ADDR_WIDTH-1:0] m_addr_nx;
    logic [SETS-1:0] valid [2];
    logic [SETS-1:0] dirty [2];
    logic [SETS-1:0] lru;
    logic [TAG_WIDTH-1:0] tags [2][SETS];
    logic [31:0] line_data [2][SETS*WORDS];
    logic hit0, hit1, hit, hit_way, req, idle, lookup, do_write, last, wb_last, fill_beat, fill_done;
    logic unused_bits;
    assign {a_tag, a_idx, a_word} = avalon_slave_address[ADDR_WIDTH-1:2];
    assign unused_bits = ^avalon_slave_address[1:0];
    assign hit0 = valid[0][a_idx] && tags[0][a_idx] == a_tag;
    assign hit1 = valid[1][a_idx] && tags[1][a_idx] == a_tag;
    assign hit = hit0 | hit1;
    assign hit_way = hit1;
    assign idle = state == IDLE;
    assign req = avalon_slave_read | avalon_slave_write;
    assign lookup = idle && hit && req;
    // a simultaneous read and write is serviced as a read only
    assign do_write = idle && hit && avalon_slave_write && !avalon_slave_read;
    assign miss_v = !valid[0][a_idx] ? 1'b0 : !valid[1][a_idx] ? 1'b1 : lru[a_idx];
    assign last = &cnt;
    assign wb_last = state == WB && !avalon_master_waitrequest && last;
    assign fill_beat = state == FILL && avalon_master_readdatavalid;
    assign fill_done = fill_beat && last;
    assign avalon_slave_waitrequest = req && !(idle && hit);
    assign avalon_slave_readdata = line_data[hit_way][{a_idx, a_word}];
    assign avalon_master_writedata = line_data[victim][{miss_idx, cnt}];
    assign avalon_master_burstcount = (LINE_WORDS_LOG2 + 1)'(WORDS);
    assign avalon_master_byteenable = 4'hF;
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        victim_nx = victim;
        miss_tag_nx = miss_tag;
        miss_idx_nx = miss_idx;
        m_read_nx = avalon_master_read;
        m_write_nx = avalon_master_write;
        m_addr_nx = avalon_master_address;
        case (state)
            IDLE: if (req && !hit) begin
                victim_nx = miss_v;
                miss_tag_nx = a_tag;
                miss_idx_nx = a_idx;
                if (valid[miss_v][a_idx] && dirty[miss_v][a_idx]) begin
                    state_nx = WB;
                    m_write_nx = 1'b1;
                    m_addr_nx = {tags[miss_v][a_idx], a_idx, {OFF{1'b0}}};
                end else begin
                    state_nx = FILL;
                    m_read_nx = 1'b1;
                    m_addr_nx = {a_tag, a_idx, {OFF{1'b0}}};
                end
            end
            WB: if (!avalon_master_waitrequest) begin
                cnt_nx = cnt + 1'b1;
                if (last) begin
                    state_nx = FILL;
                    m_write_nx = 1'b0;
                    m_read_nx = 1'b1;
                    m_addr_nx = {miss_tag, miss_idx, {OFF{1'b0}}};
                end
            end
            FILL: begin
                if (avalon_master_read && !avalon_master_waitrequest) m_read_nx = 1'b0;
                if (avalon_master_readdatavalid) begin
                    cnt_nx = cnt + 1'b1;
                    if (last) state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx = '0;
                m_read_nx = 1'b0;
                m_write_nx = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            victim <= 1'b0;
            miss_tag <= '0;
            miss_idx <= '0;
            avalon_master_read <= 1'b0;
            avalon_master_write <= 1'b0;
            avalon_master_address <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            victim <= victim_nx;
            miss_tag <= miss_tag_nx;
            miss_idx <= miss_idx_nx;
            avalon_master_read <= m_read_nx;
            avalon_master_write <= m_write_nx;
            avalon_master_address <= m_addr_nx;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid[0] <= '0;
            valid[1] <= '0;
            dirty[0] <= '0;
            dirty[1] <= '0;
            lru <= '0;
        end else begin
            if (lookup) lru[a_idx] <= !hit_way;
            if (do_write) dirty[hit_way][a_idx] <= 1'b1;
            if (wb_last) begin
                valid[victim][miss_idx] <= 1'b0;
                dirty[victim][miss_idx] <= 1'b0;
            end
            if (fill_done) begin
                valid[victim][miss_idx] <= 1'b1;
                dirty[victim][miss_idx] <= 1'b0;
                lru[miss_idx] <= !victim;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (do_write)
            for (int b = 0; b < 4; b++)
                if (avalon_slave_byteenable[b]) line_data[hit_way][{a_idx, a_word}][8*b +: 8] <= avalon_slave_writedata[8*b +: 8];
        if (fill_beat) line_data[victim][{miss_idx, cnt}] <= avalon_master_readdata;
        if (fill_done) tags[victim][miss_idx] <= miss_tag;
    end
endmodule

// File: tb/tb_cache_2way_wb.sv
// tb_cache_2way_wb: vector table, corner-case sequences and random traffic against a flat-memory reference
module tb_cache_2way_wb;
    localparam int L = 2;
    localparam int WORDS = 1 << L;
    localparam int MEM_LAT = 3;
    localparam int CLEAN = 2 + MEM_LAT + WORDS;
    localparam int DIRTY = CLEAN + WORDS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] s_addr, s_wd, s_rdata, m_addr, m_wdata, m_rdata;
    logic s_read, s_write, s_wait, m_read, m_write, m_rdv, m_wait;
    logic [3:0] s_be, m_be;
    logic [L:0] m_burst;
    logic stall_force, rand_stall, rnd_bit;
    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic mem_ready = 1'b0;
    int rd_wait, rd_left, wr_beat;
    logic [9:0] rd_ptr;
    logic [32:0] bus_log [$];

    cache_2way_wb #(.ADDR_WIDTH(32), .LINE_WORDS_LOG2(L), .INDEX_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .avalon_slave_address(s_addr), .avalon_slave_read(s_read), .avalon_slave_write(s_write),
        .avalon_slave_byteenable(s_be), .avalon_slave_writedata(s_wd),
        .avalon_slave_readdata(s_rdata), .avalon_slave_waitrequest(s_wait),
        .avalon_master_address(m_addr), .avalon_master_burstcount(m_burst),
        .avalon_master_read(m_read), .avalon_master_write(m_write),
        .avalon_master_writedata(m_wdata), .avalon_master_byteenable(m_be),
        .avalon_master_readdata(m_rdata), .avalon_master_readdatavalid(m_rdv),
        .avalon_master_waitrequest(m_wait)
    );

    always #5 clk = ~clk;
    always @(negedge clk) rnd_bit <= ($urandom_range(0, 3) == 0);
    assign m_wait = stall_force | (rand_stall & rnd_bit);

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // burst memory: one beat per cycle, first beat MEM_LAT cycles after the command is taken
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (!mem_ready) begin
                for (int i = 0; i < 1024; i++) mem[i] <= init_word(32'(i * 4));
                mem_ready <= 1'b1;
            end
            m_rdv <= 1'b0;
            rd_left <= 0;
            rd_wait <= 0;
            wr_beat <= 0;
        end else begin
            m_rdv <= 1'b0;
            if (rd_left > 0) begin
                if (rd_wait > 0) rd_wait <= rd_wait - 1;
                else begin
                    m_rdv <= 1'b1;
                    m_rdata <= mem[rd_ptr];
                    rd_ptr <= rd_ptr + 1'b1;
                    rd_left <= rd_left - 1;
                end
            end
            if (m_read && !m_wait) begin
                rd_ptr <= m_addr[11:2];
                rd_wait <= MEM_LAT - 1;
                rd_left <= WORDS;
                bus_log.push_back({1'b0, m_addr});
            end
            if (m_write && !m_wait) begin
                mem[m_addr[11:2] + 10'(wr_beat)] <= m_wdata;
                wr_beat <= (wr_beat + 1) % WORDS;
                bus_log.push_back({1'b1, m_addr + 32'(wr_beat * 4)});
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rd, output int cyc);
        s_addr = a; s_read = r; s_write = w; s_wd = d; s_be = be;
        cyc = 0;
        #1;
        while (s_wait && cyc < 300) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL op_timeout: addr %0h still waiting after %0d cycles", a, cyc);
        end
        rd = s_rdata;
        @(posedge clk);
        if (w && !r)
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
        @(negedge clk);
        s_read = 1'b0;
        s_write = 1'b0;
    endtask

    task automatic stall_on(input logic want_write, input logic [31:0] exp_addr,
                            input logic [31:0] exp_data, input int skip);
        int n = 0;
        while (!(want_write ? m_write : m_read) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(want_write ? "stall_wr_seen" : "stall_rd_seen", want_write ? m_write : m_read, 1);
        repeat (skip) @(negedge clk);
        stall_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_addr", m_addr, exp_addr);
            if (want_write) begin
                chk("stall_write", m_write, 1);
                chk("stall_data", m_wdata, exp_data);
            end else chk("stall_read", m_read, 1);
        end
        stall_force = 1'b0;
    endtask

    typedef struct {
        logic rd;
        logic wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0] be;
        logic [31:0] exp_rd;
        int exp_cyc;
    } vec_t;

    initial begin
        vec_t vt [10];
        logic [31:0] rd, w100, w104, w104c, w140, w180, exp, a, d, wexp;
        logic [3:0] be;
        logic r, w;
        int cyc, mark, n, beats, k;
        s_addr = '0; s_read = 1'b0; s_write = 1'b0; s_wd = '0; s_be = '0;
        stall_force = 1'b0; rand_stall = 1'b0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(32'(i * 4));
        w100 = init_word(32'h100);
        w104 = init_word(32'h104);
        w140 = init_word(32'h140);
        w180 = init_word(32'h180);
        w104c = {w104[31:16], 16'hCCDD};
        vt[0] = '{1'b1, 1'b0, 32'h100, 32'h0, 4'h0, w100, CLEAN};
        vt[1] = '{1'b0, 1'b1, 32'h104, 32'hAABBCCDD, 4'b0011, 32'h0, 0};
        vt[2] = '{1'b1, 1'b0, 32'h104, 32'h0, 4'h0, w104c, 0};
        vt[3] = '{1'b1, 1'b0, 32'h140, 32'h0, 4'h0, w140, CLEAN};
        vt[4] = '{1'b1, 1'b0, 32'h100, 32'h0, 4'h0, w100, 0};
        vt[5] = '{1'b1, 1'b0, 32'h180, 32'h0, 4'h0, w180, CLEAN};
        vt[6] = '{1'b1, 1'b0, 32'h140, 32'h0, 4'h0, w140, DIRTY};
        vt[7] = '{1'b1, 1'b0, 32'h104, 32'h0, 4'h0, w104c, CLEAN};
        vt[8] = '{1'b1, 1'b1, 32'h104, 32'h11111111, 4'hF, w104c, 0};
        vt[9] = '{1'b1, 1'b0, 32'h104, 32'h0, 4'h0, w104c, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_read", m_read, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_s_wait", s_wait, 0);
        chk("burstcount", m_burst, WORDS);
        chk("m_byteenable", m_be, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            op(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].be, rd, cyc);
            chk($sformatf("vec%0d_cycles", i), cyc, vt[i].exp_cyc);
            if (vt[i].rd) chk($sformatf("vec%0d_data", i), rd, vt[i].exp_rd);
        end

        // dirty line 0x100 evicted by 0x180 after 0x140 is touched
        op(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, rd, cyc);
        chk("evict_wr_cycles", cyc, 0);
        op(1'b1, 1'b0, 32'h140, 32'h0, 4'h0, rd, cyc);
        chk("evict_touch_cycles", cyc, 0);
        mark = bus_log.size();
        op(1'b1, 1'b0, 32'h180, 32'h0, 4'h0, rd, cyc);
        chk("evict_cycles", cyc, DIRTY);
        chk("evict_data", rd, w180);
        chk("evict_log_len", 64'(bus_log.size() - mark), 5);
        for (int i = 0; i < 4; i++)
            chk($sformatf("evict_wr%0d", i), bus_log[mark + i], {1'b1, 32'h100 + 32'(i * 4)});
        chk("evict_rd", bus_log[mark + 4], {1'b0, 32'h180});
        chk("evict_mem0", mem[10'h40], 32'hDEADBEEF);
        chk("evict_mem1", mem[10'h41], w104c);

        // stalls mid-writeback and on the fill command
        op(1'b0, 1'b1, 32'h180, 32'h0BADF00D, 4'hF, rd, cyc);
        op(1'b1, 1'b0, 32'h140, 32'h0, 4'h0, rd, cyc);
        wexp = ref_mem[10'h61];
        exp = ref_mem[10'h70];
        fork
            op(1'b1, 1'b0, 32'h1C0, 32'h0, 4'h0, rd, cyc);
            begin
                stall_on(1'b1, 32'h180, wexp, 1);
                stall_on(1'b0, 32'h1C0, 32'h0, 0);
            end
        join
        chk("stall_cycles", cyc, DIRTY + 10);
        chk("stall_data", rd, exp);
        for (int i = 0; i < 4; i++)
            chk($sformatf("stall_mem%0d", i), mem[10'h60 + 10'(i)], ref_mem[10'h60 + 10'(i)]);

        // reset while the fill command is held off
        stall_force = 1'b1;
        s_addr = 32'h200; s_read = 1'b1;
        n = 0;
        while (!m_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst1_read_seen", m_read, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst1_m_read", m_read, 0);
        chk("rst1_m_addr", m_addr, 0);
        s_read = 1'b0;
        stall_force = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        @(negedge clk);

        op(1'b1, 1'b0, 32'h140, 32'h0, 4'h0, rd, cyc);
        chk("rst1_refill_cycles", cyc, CLEAN);
        op(1'b1, 1'b0, 32'h140, 32'h0, 4'h0, rd, cyc);
        chk("pre_rst2_hit_cycles", cyc, 0);

        // reset during the second fill beat
        s_addr = 32'h100; s_read = 1'b1;
        n = 0; beats = 0;
        while (beats < 2 && n < 100) begin
            @(negedge clk);
            n++;
            if (m_rdv) beats++;
        end
        chk("rst2_beat2_seen", beats, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_m_read", m_read, 0);
        chk("rst2_m_write", m_write, 0);
        s_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        @(negedge clk);
        op(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, rd, cyc);
        chk("rst2_0x100_cycles", cyc, CLEAN);
        chk("rst2_0x100_data", rd, ref_mem[10'h40]);
        op(1'b1, 1'b0, 32'h140, 32'h0, 4'h0, rd, cyc);
        chk("rst2_0x140_cycles", cyc, CLEAN);

        // random traffic with random memory stalls
        rand_stall = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = 32'($urandom_range(0, 255)) << 2;
            k = $urandom_range(0, 9);
            r = (k < 6) || (k == 9);
            w = k >= 6;
            d = $urandom;
            be = 4'($urandom);
            exp = ref_mem[a[11:2]];
            op(r, w, a, d, be, rd, cyc);
            if (r) chk($sformatf("rand%0d_read_%0h", i, a), rd, exp);
        end
        rand_stall = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end
endmodule
